// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_dbg_pkg
// Brief  : Shared FSM states, dump_sel encodings and default widths for the
//          MIPS run-and-dump controller.
// Rev    : 1.0
// ============================================================================
package mips_dbg_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_COUNT  = 32;
    localparam int DEF_MEM_DEPTH  = 32;
    localparam int DEF_MAX_CYCLES = 10;
    localparam int DEF_CNT_W      = 16;

    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_CHK = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_RUN      = 3'd2,
        ST_DREG_RD  = 3'd3,
        ST_DREG_OUT = 3'd4,
        ST_DMEM_RD  = 3'd5,
        ST_DMEM_OUT = 3'd6,
        ST_CHK_OUT  = 3'd7
    } state_t;

    // Address width that stays legal for a single-entry array.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dump_beat_reg.sv
`default_nettype none
// ============================================================================
// Module : dump_beat_reg
// Brief  : Output beat register; holds a loaded word until valid/ready accept.
// Rev    : 1.0
// ============================================================================
module dump_beat_reg #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_sel,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_sel,
    output logic [IDX_W-1:0]  o_idx
);

    // A load in the same cycle as an accept replaces the beat, so valid stays high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
            o_idx   <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_sel   <= i_sel;
            o_idx   <= i_idx;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_run_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mips_run_dump_ctrl
// Brief  : Resets and runs the core for a bounded cycle count or until halt,
//          then streams registers and data memory over valid/ready.
//          Define RUN_DUMP_CHECKSUM_EN to append a trailing XOR checksum beat.
// Rev    : 1.0
// ============================================================================
module mips_run_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_COUNT  = DEF_REG_COUNT,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_W-1:0]             run_cycles,
    input  logic                         halt_in,
    output logic                         core_en,
    output logic                         core_rst_n,
    output logic [addr_w(REG_COUNT)-1:0] dbg_reg_addr,
    input  logic [DATA_W-1:0]            dbg_reg_data,
    output logic [addr_w(MEM_DEPTH)-1:0] dbg_mem_addr,
    input  logic [DATA_W-1:0]            dbg_mem_data,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [DATA_W-1:0]            dump_data,
    output logic [1:0]                   dump_sel,
    output logic [CNT_W-1:0]             dump_idx,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             cycles_run
);

    localparam int               c_ra_w     = addr_w(REG_COUNT);
    localparam int               c_ma_w     = addr_w(MEM_DEPTH);
    localparam logic [CNT_W-1:0] c_reg_last = CNT_W'(REG_COUNT - 1);
    localparam logic [CNT_W-1:0] c_mem_last = CNT_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] c_max_cyc  = CNT_W'(MAX_CYCLES);

    state_t             r_state;
    logic [CNT_W-1:0]   r_limit;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   w_idx_inc;
    logic [CNT_W-1:0]   w_cyc_inc;
    logic               w_hs;
    logic               w_reg_last;
    logic               w_mem_last;
    logic               w_load;
    logic [DATA_W-1:0]  w_load_data;
    logic [1:0]         w_load_sel;
    logic [CNT_W-1:0]   w_load_idx;
`ifdef RUN_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]  r_chk;
`endif

    assign w_idx_inc  = r_idx + 1'b1;
    assign w_cyc_inc  = (cycles_run == '1) ? cycles_run : cycles_run + 1'b1;
    assign w_hs       = dump_valid && dump_ready;
    assign w_reg_last = (r_idx == c_reg_last);
    assign w_mem_last = (r_idx == c_mem_last);

    // Read data is captured on the edge that leaves a *_RD state.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = '0;
        w_load_sel  = SEL_REG;
        w_load_idx  = r_idx;
        case (r_state)
            ST_DREG_RD: begin
                w_load      = 1'b1;
                w_load_data = dbg_reg_data;
            end
            ST_DMEM_RD: begin
                w_load      = 1'b1;
                w_load_data = dbg_mem_data;
                w_load_sel  = SEL_MEM;
            end
`ifdef RUN_DUMP_CHECKSUM_EN
            ST_DMEM_OUT: begin
                if (w_hs && w_mem_last) begin
                    w_load      = 1'b1;
                    w_load_data = r_chk;
                    w_load_sel  = SEL_CHK;
                    w_load_idx  = '0;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_limit      <= '0;
            r_idx        <= '0;
            core_en      <= 1'b0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cycles_run   <= '0;
            dbg_reg_addr <= '0;
            dbg_mem_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    core_en    <= 1'b0;
                    core_rst_n <= 1'b0;
                    if (start) begin
                        r_limit    <= (run_cycles == '0) ? c_max_cyc : run_cycles;
                        r_idx      <= '0;
                        cycles_run <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= ST_CORE_RST;
                    end
                end
                ST_CORE_RST: begin
                    core_en    <= 1'b1;
                    core_rst_n <= 1'b1;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    cycles_run <= w_cyc_inc;
                    if ((w_cyc_inc == r_limit) || halt_in) begin
                        core_en <= 1'b0;
                        r_idx   <= '0;
                        r_state <= ST_DREG_RD;
                    end
                end
                // Addresses advance at capture so the next word is already being read.
                ST_DREG_RD: begin
                    dbg_reg_addr <= w_reg_last ? '0 : w_idx_inc[c_ra_w-1:0];
                    r_state      <= ST_DREG_OUT;
                end
                ST_DREG_OUT: begin
                    if (w_hs) begin
                        r_idx   <= w_reg_last ? '0 : w_idx_inc;
                        r_state <= w_reg_last ? ST_DMEM_RD : ST_DREG_RD;
                    end
                end
                ST_DMEM_RD: begin
                    dbg_mem_addr <= w_mem_last ? '0 : w_idx_inc[c_ma_w-1:0];
                    r_state      <= ST_DMEM_OUT;
                end
                ST_DMEM_OUT: begin
                    if (w_hs) begin
                        if (!w_mem_last) begin
                            r_idx   <= w_idx_inc;
                            r_state <= ST_DMEM_RD;
                        end else begin
`ifdef RUN_DUMP_CHECKSUM_EN
                            r_idx   <= '0;
                            r_state <= ST_CHK_OUT;
`else
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            core_rst_n <= 1'b0;
                            r_state    <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef RUN_DUMP_CHECKSUM_EN
                ST_CHK_OUT: begin
                    if (w_hs) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef RUN_DUMP_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_chk <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_chk <= '0;
        end else if (r_state == ST_DREG_RD || r_state == ST_DMEM_RD) begin
            r_chk <= r_chk ^ w_load_data;
        end
    end
`endif

    dump_beat_reg #(
        .DATA_W (DATA_W),
        .IDX_W  (CNT_W)
    ) u_beat (
        .clk     (clock),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_sel   (w_load_sel),
        .i_idx   (w_load_idx),
        .i_ready (dump_ready),
        .o_valid (dump_valid),
        .o_data  (dump_data),
        .o_sel   (dump_sel),
        .o_idx   (dump_idx)
    );

endmodule
`default_nettype wire

// File: doc/mips_run_dump_ctrl.md
Name: mips_run_dump_ctrl

Overview:
Synthesizable run-and-dump controller that sits beside mips_core in simulation and FPGA bring-up. It holds the core in reset, enables it for a programmed number of cycles or until halt, then streams the register file and data memory out over a valid/ready port. It replaces fixed-length clock loops and end-of-run file dumps with a parametrised, handshaked sequencer.

Parameters:
DATA_W, 32, word width of register file, memory and dump port
REG_COUNT, 32, registers dumped (indices 0..REG_COUNT-1)
MEM_DEPTH, 32, data-memory words dumped (word indices 0..MEM_DEPTH-1)
MAX_CYCLES, 10, run length used when run_cycles == 0
CNT_W, 16, width of cycle counters

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low; sampled on rising clock edge
start  in  1  one-cycle pulse; begins a run when idle
run_cycles  in  CNT_W  cycles to run; 0 selects MAX_CYCLES
halt_in  in  1  core halt indication, sampled only in RUN
core_en  out  1  clock enable to core
core_rst_n  out  1  active-low reset to core
dbg_reg_addr  out  clog2(REG_COUNT)  register-file debug read address
dbg_reg_data  in  DATA_W  register read data, valid 1 cycle after address
dbg_mem_addr  out  clog2(MEM_DEPTH)  data-memory debug word address
dbg_mem_data  in  DATA_W  memory read data, valid 1 cycle after address
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts word
dump_data  out  DATA_W  dumped word
dump_sel  out  2  0=register, 1=memory, 2=checksum
dump_idx  out  CNT_W  register/word index of dump_data
busy  out  1  high from start acceptance until DONE
done  out  1  sticky completion flag
cycles_run  out  CNT_W  enabled cycles in last run, saturating

Behaviour:
- Reset (reset==0 at edge): state IDLE; core_en=0, core_rst_n=0, dump_valid=0, dump_data=0, dump_sel=0, dump_idx=0, busy=0, done=0, cycles_run=0, addresses=0. Applies mid-operation; an in-flight dump word is dropped.
- IDLE: core_rst_n=0. start=1 -> latch limit (run_cycles, or MAX_CYCLES if 0), clear cycles_run and done, busy=1 -> CORE_RST.
- CORE_RST: exactly one cycle, core_rst_n=0, core_en=0 -> RUN.
- RUN: core_rst_n=1, core_en=1. cycles_run increments each RUN cycle and saturates at all-ones. Leave for DREG_RD after the cycle in which cycles_run reaches limit, or the cycle halt_in=1 (that cycle counts). Halt and limit in the same cycle -> single exit, count includes that cycle.
- Post-run: core_en=0, core_rst_n=1 (state preserved for reads).
- DREG_RD: drive dbg_reg_addr=idx; next cycle -> DREG_OUT, capture dbg_reg_data into dump_data, dump_sel=0, dump_idx=idx, dump_valid=1.
- DREG_OUT: hold dump_data/sel/idx stable while dump_valid && !dump_ready. On handshake: last register -> DMEM_RD with idx=0, else idx+1 -> DREG_RD. Throughput: one word per 2 cycles max.
- DMEM_RD/DMEM_OUT: identical, using dbg_mem_*, dump_sel=1.
- After last memory handshake -> DONE (or CHK_OUT if feature enabled).
- DONE: busy=0, done=1 held until next start or reset; -> IDLE same cycle. start while busy ignored.
- start asserted in cycle of reset: reset wins.

Optional Feature:
RUN_DUMP_CHECKSUM_EN: defined -> running XOR of every dumped word (registers then memory); after last memory word emits one extra beat dump_sel=2, dump_idx=0, dump_data=XOR, same handshake, then DONE. Undefined -> no checksum logic, dump_sel never 2, DONE directly after last memory word.

Decomposition:
- Shared package mips_dbg_pkg: FSM state enum, dump_sel encoding constants (SEL_REG, SEL_MEM, SEL_CHK), default widths.
- One sub-module natural: dump_beat_reg (output holding register implementing valid/ready hold-until-accepted); FSM and counters stay in top.

Test Plan:
- run_cycles=0, halt_in=0, dump_ready=1 -> core_en high exactly 10 cycles, cycles_run=10, 32 reg beats (dump_idx 0..31, sel 0) then 32 mem beats (sel 1), done=1.
- run_cycles=100, halt_in pulsed in RUN cycle 7 -> cycles_run=7, core_en deasserts next cycle, dump follows.
- dump_ready held low 5 cycles on register 3 -> dump_valid stays 1, dump_data/dump_idx=3 unchanged, no skipped or duplicated index.
- reset driven low during memory word 10 -> next cycle all outputs at reset values, state IDLE, core_rst_n=0; new start runs full sequence.
- start pulsed while busy -> ignored, cycles_run unaffected; run_cycles=16'hFFFF with REG_COUNT=4, MEM_DEPTH=4 -> cycles_run=65535, 8 beats.
- RUN_DUMP_CHECKSUM_EN defined, all registers 0, mem words 0x1,0x2,0x4,... -> final beat sel=2 with XOR of all dumped words.
